// File: rtl/wm_phase_timer.sv
// Phase timer for the washing-machine controller: times the detergent, wash and spin phases
// and watches fill/drain for overruns, producing the FSM's stop pulse and a sticky fault.
module wm_phase_timer #(
  parameter int PRESCALE    = 50_000_000,
  parameter int CNT_W       = 16,
  parameter int DET_TICKS   = 10,
  parameter int WASH_TICKS  = 600,
  parameter int SPIN_TICKS  = 300,
  parameter int FILL_TICKS  = 120,
  parameter int DRAIN_TICKS = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [2:0]       phase_code,
  input  logic             fault_clr,
  output logic             stop,
  output logic             fault,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [2:0] CODE_FILL  = 3'b001;
  localparam logic [2:0] CODE_DET   = 3'b010;
  localparam logic [2:0] CODE_WASH  = 3'b011;
  localparam logic [2:0] CODE_DRAIN = 3'b100;
  localparam logic [2:0] CODE_SPIN  = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [PS_W-1:0] prescaler;
  logic [2:0]      phase_q;
  logic            phase_change;
  logic [CNT_W-1:0] load_d;

  function automatic logic [CNT_W-1:0] duration(input logic [2:0] code);
    logic [CNT_W-1:0] d;
    d = '0;
    case (code)
      CODE_FILL:  d = CNT_W'(FILL_TICKS);
      CODE_DET:   d = CNT_W'(DET_TICKS);
      CODE_WASH:  d = CNT_W'(WASH_TICKS);
      CODE_DRAIN: d = CNT_W'(DRAIN_TICKS);
      CODE_SPIN:  d = CNT_W'(SPIN_TICKS);
      default:    d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_pulse_phase(input logic [2:0] code);
    return (code == CODE_DET) || (code == CODE_WASH) || (code == CODE_SPIN);
  endfunction

  function automatic logic is_watchdog_phase(input logic [2:0] code);
    return (code == CODE_FILL) || (code == CODE_DRAIN);
  endfunction

  assign phase_change = (phase_code != phase_q);
  assign load_d       = duration(phase_code);

  // A phase change is checked before expiry so a new phase always reloads cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stop      <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
      prescaler <= '0;
      phase_q   <= 3'b000;
    end else begin
      phase_q <= phase_code;
      stop    <= 1'b0;
      if (fault_clr) begin
        fault <= 1'b0;
      end

      if (!start) begin
        state     <= IDLE;
        busy      <= 1'b0;
        remaining <= '0;
        prescaler <= '0;
      end else if (phase_change || state == IDLE) begin
        prescaler <= '0;
        if (is_pulse_phase(phase_code) || is_watchdog_phase(phase_code)) begin
          if (load_d == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            remaining <= '0;
            if (is_pulse_phase(phase_code)) begin
              stop <= 1'b1;
            end
            if (is_watchdog_phase(phase_code)) begin
              fault <= 1'b1;
            end
          end else begin
            state     <= COUNT;
            busy      <= 1'b1;
            remaining <= load_d;
          end
        end else begin
          state     <= IDLE;
          busy      <= 1'b0;
          remaining <= '0;
        end
      end else if (state == COUNT && !pause) begin
        if (prescaler == PS_LAST) begin
          prescaler <= '0;
          // Last tick of the phase: fire stop or fault depending on phase kind.
          if (remaining <= CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            remaining <= '0;
            if (is_pulse_phase(phase_code)) begin
              stop <= 1'b1;
            end
            if (is_watchdog_phase(phase_code)) begin
              fault <= 1'b1;
            end
          end else begin
            remaining <= remaining - CNT_W'(1);
          end
        end else begin
          prescaler <= prescaler + PS_W'(1);
        end
      end
    end
  end

endmodule
